fir_transposed: RTL and testbench

//  Transposed-form (reversed signal-flow) counterpart of the team's direct-form FIR: identical transfer

---
 rtl/fir_transposed.sv | 63 ++++++
 tb/tb_fir_transposed.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/fir_transposed.sv
// fir_transposed: transposed-form FIR with ready/valid handshakes, round-half-up scaling and output saturation
module fir_transposed #(
   parameter int IW = 8,
   parameter int OW = 9,
   parameter int NTAPS = 4,
   parameter int CW = 4,
   parameter logic signed [CW-1:0] COEFFS [NTAPS] = '{4'sd1, 4'sd2, 4'sd3, 4'sd4},
   parameter int SHIFT = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [IW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [OW-1:0] out_data,
   output logic          out_sat
);
   localparam int AW = IW + CW + $clog2(NTAPS);
   localparam logic signed [AW:0] HALF = SHIFT == 0 ? '0 : (AW+1)'(1) <<< (SHIFT == 0 ? 0 : SHIFT - 1);
   localparam logic signed [AW:0] MAXV = (AW+1)'((1 <<< (OW - 1)) - 1);
   localparam logic signed [AW:0] MINV = -(AW+1)'(1 <<< (OW - 1));
   logic signed [AW-1:0] s [NTAPS-1];
   logic signed [AW-1:0] sx [NTAPS];
   logic signed [AW-1:0] prod [NTAPS];
   logic signed [AW-1:0] nxt [NTAPS-1];
   logic signed [AW-1:0] acc;
   logic signed [AW:0] r;
   logic accept, sat_hi, sat_lo;
   assign in_ready = !rst && !flush && (!out_valid || out_ready);
   assign accept = in_valid && in_ready;
   // sx pads the partial-sum chain with a zero so the last tap needs no special case
   always_comb begin
      for (int k = 0; k < NTAPS; k++) prod[k] = AW'(COEFFS[k]) * AW'($signed(in_data));
      for (int k = 0; k < NTAPS - 1; k++) sx[k] = s[k];
      sx[NTAPS-1] = '0;
      for (int k = 0; k < NTAPS - 1; k++) nxt[k] = prod[k + 1] + sx[k + 1];
      acc = prod[0] + s[0];
      r = ((AW+1)'(acc) + HALF) >>> SHIFT;
      sat_hi = r > MAXV;
      sat_lo = r < MINV;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NTAPS - 1; k++) s[k] <= '0;
         out_valid <= 1'b0;
         out_data <= '0;
         out_sat <= 1'b0;
      end else if (flush) begin
         for (int k = 0; k < NTAPS - 1; k++) s[k] <= '0;
         out_valid <= 1'b0;
      end else if (accept) begin
         for (int k = 0; k < NTAPS - 1; k++) s[k] <= nxt[k];
         out_valid <= 1'b1;
         out_data <= sat_hi ? MAXV[OW-1:0] : sat_lo ? MINV[OW-1:0] : r[OW-1:0];
         out_sat <= sat_hi || sat_lo;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_fir_transposed.sv
// tb_fir_transposed: direct-form golden model with per-cycle compare plus literal directed sequences
module tb_fir_transposed;
   logic clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 1;
   logic [7:0] in_data = 0;
   logic in_ready, out_valid, out_sat;
   logic [8:0] out_data;
   int n_vec = 0, n_bad = 0, n_acc = 0;
   localparam int C [4] = '{1, 2, 3, 4};
   int hist [4] = '{0, 0, 0, 0};
   int mv = 0, md = 0, ms = 0, macc, mr, target;
   int rec_d[$], exp_d[$];
   bit rec_s[$], exp_s[$];
   always #5 clk = ~clk;
   fir_transposed dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat)
   );
   function automatic int floor_div(int a, int b);
      int q = a / b;
      if ((a % b != 0) && ((a < 0) != (b < 0))) q--;
      return q;
   endfunction
   function automatic bit m_ready();
      return !rst && !flush && (mv == 0 || out_ready);
   endfunction
   task automatic chk(string name, int got, int want);
      n_vec++;
      if (got != want) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, got, want);
      end
   endtask
   // golden model: y = sum C[k]*x[n-k], floor((y+2)/4), clip to 9 bits
   always @(posedge clk) begin
      if (rst) begin
         foreach (hist[i]) hist[i] = 0;
         mv = 0; md = 0; ms = 0;
      end else if (flush) begin
         foreach (hist[i]) hist[i] = 0;
         mv = 0;
      end else if (in_valid && m_ready()) begin
         for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
         hist[0] = int'($signed(in_data));
         macc = 0;
         for (int i = 0; i < 4; i++) macc += C[i] * hist[i];
         mr = floor_div(macc + 2, 4);
         ms = (mr > 255 || mr < -256) ? 1 : 0;
         md = mr > 255 ? 255 : mr < -256 ? -256 : mr;
         mv = 1;
         n_acc++;
      end else if (out_ready) mv = 0;
   end
   always @(negedge clk) begin
      chk("out_valid", out_valid, mv);
      chk("in_ready", in_ready, m_ready());
      if (mv != 0) begin
         chk("out_data", $signed(out_data), md);
         chk("out_sat", out_sat, ms);
      end
      if (!rst && !flush && out_valid && out_ready) begin
         rec_d.push_back(int'($signed(out_data)));
         rec_s.push_back(out_sat);
      end
   end
   task automatic send(int x);
      bit ok = 0;
      in_valid = 1; in_data = 8'(x);
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         ok = in_ready;
      end
      if (!ok) chk("send timeout", 0, 1);
      @(posedge clk); #1 in_valid = 0;
   endtask
   task automatic do_flush();
      flush = 1;
      @(posedge clk); #1 flush = 0;
   endtask
   task automatic drain();
      repeat (3) @(posedge clk);
      #1;
   endtask
   task automatic check_seq(string name);
      chk({name, " count"}, rec_d.size(), exp_d.size());
      for (int i = 0; i < rec_d.size() && i < exp_d.size(); i++) begin
         chk($sformatf("%s data[%0d]", name, i), rec_d[i], exp_d[i]);
         chk($sformatf("%s sat[%0d]", name, i), rec_s[i], exp_s[i]);
      end
      rec_d.delete(); rec_s.delete();
   endtask
   initial begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst in_ready", in_ready, 0);
      chk("rst out_valid", out_valid, 0);
      chk("rst out_data", out_data, 0);
      chk("rst out_sat", out_sat, 0);
      @(posedge clk); #1 rst = 0;
      @(negedge clk);
      chk("post-rst in_ready", in_ready, 1);
      @(posedge clk); #1;
      rec_d.delete(); rec_s.delete();
      send(64);
      repeat (5) send(0);
      drain();
      exp_d = '{16, 32, 48, 64, 0, 0}; exp_s = '{0, 0, 0, 0, 0, 0};
      check_seq("impulse");
      do_flush();
      repeat (5) send(127);
      drain();
      exp_d = '{32, 95, 191, 255, 255}; exp_s = '{0, 0, 0, 1, 1};
      check_seq("pos step");
      do_flush();
      repeat (4) send(-128);
      drain();
      exp_d = '{-32, -96, -192, -256}; exp_s = '{0, 0, 0, 1};
      check_seq("neg step");
      do_flush(); send(2); drain();
      do_flush(); send(-2); drain();
      do_flush(); send(1); drain();
      exp_d = '{1, 0, 0}; exp_s = '{0, 0, 0};
      check_seq("rounding");
      do_flush();
      out_ready = 0;
      send(64);
      repeat (3) begin
         @(negedge clk);
         chk("hold out_valid", out_valid, 1);
         chk("hold out_data", $signed(out_data), 16);
         chk("hold in_ready", in_ready, 0);
      end
      @(posedge clk); #1 out_ready = 1;
      repeat (3) send(0);
      drain();
      exp_d = '{16, 32, 48, 64}; exp_s = '{0, 0, 0, 0};
      check_seq("backpressure");
      do_flush();
      send(100); send(100);
      do_flush();
      rec_d.delete(); rec_s.delete();
      send(64);
      repeat (3) send(0);
      drain();
      exp_d = '{16, 32, 48, 64}; exp_s = '{0, 0, 0, 0};
      check_seq("flush");
      target = n_acc + 10000;
      for (int cyc = 0; cyc < 40000 && n_acc < target; cyc++) begin
         @(posedge clk); #1;
         in_valid = $urandom_range(0, 9) < 7;
         in_data = 8'($urandom);
         out_ready = $urandom_range(0, 9) < 7;
         flush = $urandom_range(0, 99) == 0;
         rst = cyc == 3000;
      end
      in_valid = 0; flush = 0; rst = 0; out_ready = 1;
      drain();
      chk("random samples accepted", n_acc >= target, 1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
